// File: rtl/c64_bus_pkg.sv
// Shared types and widths for the C64 bus scheduler.
package c64_bus_pkg;
  typedef enum logic [1:0] {IDLE, WARN, STEAL} state_t;

  localparam int DMA_LEN_W = 7;

  function automatic int tick_w(input int half_clks);
    return $clog2(2 * half_clks);
  endfunction
endpackage

// File: rtl/c64_bus_tick.sv
// Bus-cycle tick counter and its decodes: phase, in-half position, cycle/half boundaries.
module c64_bus_tick
  import c64_bus_pkg::*;
#(
  parameter int HALF_CLKS = 8,
  parameter int TICK_W    = tick_w(HALF_CLKS)
) (
  input  logic              clk,
  input  logic              rst,
  output logic [TICK_W-1:0] htick,
  output logic              phi2_c,
  output logic              cycle_start_c,
  output logic              half_end,
  output logic              last_tick
);
  localparam logic [TICK_W-1:0] HALF  = TICK_W'(HALF_CLKS);
  localparam logic [TICK_W-1:0] HLAST = TICK_W'(HALF_CLKS - 1);
  localparam logic [TICK_W-1:0] LAST  = TICK_W'(2 * HALF_CLKS - 1);

  logic [TICK_W-1:0] tick;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)            tick <= '0;
    else if (last_tick) tick <= '0;
    else                tick <= tick + 1'b1;
  end

  assign last_tick     = (tick == LAST);
  assign phi2_c        = (tick >= HALF);
  assign htick         = phi2_c ? (tick - HALF) : tick;
  assign half_end      = (tick == HLAST) || last_tick;
  assign cycle_start_c = (tick == '0);
endmodule

// File: rtl/c64_bus_sched.sv
// C64 shared-bus scheduler: phi2/AECn/BA, DRAM RAS/CAS strobes and VIC cycle stealing.
// Optional RAS-only refresh scheduling is enabled by defining C64_BUS_REFRESH_EN.
module c64_bus_sched
  import c64_bus_pkg::*;
#(
  parameter int HALF_CLKS      = 8,
  parameter int RAS_TICK       = 2,
  parameter int CAS_TICK       = 4,
  parameter int WARN_CYCLES    = 3,
  parameter int LINE_CYCLES    = 63,
  parameter int REFRESH_START  = 11,
  parameter int REFRESH_CYCLES = 5
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 dma_req,
  input  logic [DMA_LEN_W-1:0] dma_len,
  output logic                 phi2,
  output logic                 AECn,
  output logic                 BA,
  output logic                 RASn,
  output logic                 CASn,
  output logic                 dma_active,
  output logic                 cycle_start,
  output logic [7:0]           refresh_row
);
  localparam int TICK_W = tick_w(HALF_CLKS);
  localparam int WARN_W = (WARN_CYCLES < 2) ? 1 : $clog2(WARN_CYCLES + 1);

  logic [TICK_W-1:0] htick;
  logic phi2_c, cycle_start_c, half_end, last_tick, refresh_cas;

  c64_bus_tick #(.HALF_CLKS(HALF_CLKS)) u_tick (
    .clk          (clk),
    .rst          (rst),
    .htick        (htick),
    .phi2_c       (phi2_c),
    .cycle_start_c(cycle_start_c),
    .half_end     (half_end),
    .last_tick    (last_tick)
  );

  state_t state, state_n;
  logic [WARN_W-1:0]    warn_cnt, warn_n;
  logic [DMA_LEN_W-1:0] steal_cnt, steal_n, len_q, len_n, len_eff;

  assign len_eff = (dma_len == '0) ? DMA_LEN_W'(1) : dma_len;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      warn_cnt  <= '0;
      steal_cnt <= '0;
      len_q     <= '0;
    end else begin
      state     <= state_n;
      warn_cnt  <= warn_n;
      steal_cnt <= steal_n;
      len_q     <= len_n;
    end
  end

  // Decisions are taken only on the last tick so every bus cycle has a single owner.
  always_comb begin
    state_n = state;
    warn_n  = warn_cnt;
    steal_n = steal_cnt;
    len_n   = len_q;
    if (last_tick) begin
      unique case (state)
        IDLE: if (dma_req) begin
          len_n = len_eff;
          if (WARN_CYCLES == 0) begin
            state_n = STEAL;
            steal_n = len_eff;
          end else begin
            state_n = WARN;
            warn_n  = WARN_W'(WARN_CYCLES);
          end
        end
        WARN: if (warn_cnt == WARN_W'(1)) begin
          state_n = STEAL;
          steal_n = len_q;
        end else begin
          warn_n = warn_cnt - 1'b1;
        end
        STEAL: if (steal_cnt == DMA_LEN_W'(1)) begin
          // Back-to-back grant keeps BA low; no second warning window.
          if (dma_req) steal_n = len_eff;
          else         state_n = IDLE;
        end else begin
          steal_n = steal_cnt - 1'b1;
        end
        default: state_n = IDLE;
      endcase
    end
  end

`ifdef C64_BUS_REFRESH_EN
  localparam int LINE_W = (LINE_CYCLES < 2) ? 1 : $clog2(LINE_CYCLES);

  logic [LINE_W-1:0] line_q;
  logic              in_refresh;

  assign in_refresh  = (line_q >= LINE_W'(REFRESH_START)) &&
                       (line_q <  LINE_W'(REFRESH_START + REFRESH_CYCLES));
  assign refresh_cas = in_refresh && !phi2_c;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      line_q      <= '0;
      refresh_row <= 8'h00;
    end else begin
      if (last_tick)
        line_q <= (line_q == LINE_W'(LINE_CYCLES - 1)) ? '0 : line_q + 1'b1;
      if (half_end && refresh_cas)
        refresh_row <= refresh_row + 8'h01;
    end
  end
`else
  logic unused_refresh;

  // Refresh parameters and the half-end strobe only matter in the refresh build.
  assign unused_refresh = ^{half_end, LINE_CYCLES[0], REFRESH_START[0], REFRESH_CYCLES[0]};
  assign refresh_cas    = 1'b0;
  assign refresh_row    = 8'h00;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      phi2        <= 1'b0;
      AECn        <= 1'b1;
      BA          <= 1'b1;
      RASn        <= 1'b1;
      CASn        <= 1'b1;
      dma_active  <= 1'b0;
      cycle_start <= 1'b0;
    end else begin
      phi2        <= phi2_c;
      AECn        <= !phi2_c || (state == STEAL);
      BA          <= (state == IDLE);
      RASn        <= (htick < TICK_W'(RAS_TICK));
      CASn        <= (htick < TICK_W'(CAS_TICK)) || refresh_cas;
      dma_active  <= (state == STEAL);
      cycle_start <= cycle_start_c;
    end
  end
endmodule
